// File: rtl/rv32i_pkg.sv
// Shared encodings for the single-cycle RV32I control/execute slice:
// opcodes, ALU control codes and datapath mux selects.
package rv32i_pkg;

  localparam int unsigned OP_W = 7;

  localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
  localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;
  localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
  localparam logic [OP_W-1:0] OP_JAL  = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Coarse ALU intent from the main decoder; FUNCT defers to funct3/bit 30.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/rv32i_alu.sv
// 32-bit ALU: add/sub/and/or/signed-slt with a zero flag; unused codes give 0.
module rv32i_alu
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      alu_ctrl,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (alu_ctrl)
      ALU_ADD: y = src_a + src_b;
      ALU_SUB: y = src_a - src_b;
      ALU_AND: y = src_a & src_b;
      ALU_OR:  y = src_a | src_b;
      ALU_SLT: y = XLEN'($signed(src_a) < $signed(src_b));
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/rv32i_exec_ctrl.sv
// Control, execute and next-PC block of the single-cycle RV32I core.
// Only pc is registered; every other output follows instr/operands/pc combinationally.
module rv32i_exec_ctrl
  import rv32i_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] read_data,
  output logic [XLEN-1:0] pc,
  output logic [1:0]      imm_src,
  output logic            reg_write,
  output logic            mem_write,
  output logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] write_data,
  output logic [XLEN-1:0] result
);

  logic [OP_W-1:0] op;
  logic [2:0]      funct3;
  logic            branch;
  logic            jump;
  logic            alu_src;
  logic [1:0]      result_src;
  logic [1:0]      alu_op;
  alu_ctrl_t       alu_ctrl;
  logic [XLEN-1:0] src_b;
  logic            zero;
  logic            pc_src;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc_next;
  logic            unused_instr_bits;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // Main decoder; unknown opcodes fall through to a side-effect-free NOP.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    imm_src    = IMM_I;
    alu_src    = 1'b0;
    result_src = RES_ALU;
    alu_op     = ALUOP_ADD;
    case (op)
      OP_LW: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OP_SW: begin
        mem_write = 1'b1;
        imm_src   = IMM_S;
        alu_src   = 1'b1;
      end
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_IALU: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        branch  = 1'b1;
        imm_src = IMM_B;
        alu_op  = ALUOP_SUB;
      end
      OP_JAL: begin
        jump       = 1'b1;
        reg_write  = 1'b1;
        imm_src    = IMM_J;
        result_src = RES_PC4;
      end
      default: ;
    endcase
  end

  // ALU function decode; op[5] separates R-type from I-type so addi never subtracts.
  always_comb begin
    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_ctrl = (op[5] && instr[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_ctrl = ALU_SLT;
          3'b110:  alu_ctrl = ALU_OR;
          3'b111:  alu_ctrl = ALU_AND;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

  assign src_b = alu_src ? imm_ext : rd2;

  rv32i_alu #(.XLEN(XLEN)) u_alu (
    .src_a    (rd1),
    .src_b    (src_b),
    .alu_ctrl (alu_ctrl),
    .y        (alu_result),
    .zero     (zero)
  );

  assign pc_plus4   = pc + XLEN'(4);
  assign pc_target  = pc + imm_ext;
  assign pc_src     = (branch & zero) | jump;
  assign pc_next    = pc_src ? pc_target : pc_plus4;
  assign write_data = rd2;

  always_comb begin
    case (result_src)
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= RESET_PC;
    else       pc <= pc_next;
  end

endmodule

// File: tb/tb_rv32i_exec_ctrl.sv
// Scoreboard bench for rv32i_exec_ctrl: directed cases then randomized
// instructions, each checked against an instruction-level reference model.
module tb_rv32i_exec_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  localparam logic [6:0] T_LW   = 7'b0000011;
  localparam logic [6:0] T_SW   = 7'b0100011;
  localparam logic [6:0] T_R    = 7'b0110011;
  localparam logic [6:0] T_I    = 7'b0010011;
  localparam logic [6:0] T_BEQ  = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;

  localparam logic [31:0] I_ADDI   = 32'h0050_0093;
  localparam logic [31:0] I_SUB    = 32'h4020_8133;
  localparam logic [31:0] I_ADDI30 = 32'h4020_8113;
  localparam logic [31:0] I_SLT    = 32'h0020_A133;
  localparam logic [31:0] I_BEQ    = 32'h0020_8063;
  localparam logic [31:0] I_JAL    = 32'h0000_00EF;
  localparam logic [31:0] I_LW     = 32'h0000_A103;
  localparam logic [31:0] I_SW     = 32'h0020_A023;
  localparam logic [31:0] I_NOP    = 32'h0000_0000;

  typedef struct {
    bit          pc_only;
    logic [31:0] pc;
    logic [1:0]  imm_src;
    logic        rw;
    logic        mw;
    bit          chk_alu;
    logic [31:0] alu;
    bit          chk_res;
    logic [31:0] res;
    logic [31:0] wd;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = '0, rd1 = '0, rd2 = '0, imm_ext = '0, read_data = '0;
  logic [31:0] pc, alu_result, write_data, result;
  logic [1:0]  imm_src;
  logic        reg_write, mem_write;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] model_pc;
  logic        mon_req = 1'b0;

  rv32i_exec_ctrl #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .rd1        (rd1),
    .rd2        (rd2),
    .imm_ext    (imm_ext),
    .read_data  (read_data),
    .pc         (pc),
    .imm_src    (imm_src),
    .reg_write  (reg_write),
    .mem_write  (mem_write),
    .alu_result (alu_result),
    .write_data (write_data),
    .result     (result)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, expv);
    end
  endtask

  // R/I-type arithmetic straight from the instruction-set rules.
  function automatic logic [31:0] funct_op(input logic [31:0] i, input logic [31:0] a,
                                           input logic [31:0] b, input bit is_r);
    case (i[14:12])
      3'b000:  return (is_r && i[30]) ? a - b : a + b;
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return a + b;
    endcase
  endfunction

  task automatic model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic [31:0] rdat, input logic [31:0] p,
                       input string tag, output exp_t x, output logic [31:0] nxt);
    x = '{pc_only: 1'b0, pc: p, imm_src: 2'b00, rw: 1'b0, mw: 1'b0, chk_alu: 1'b0,
          alu: '0, chk_res: 1'b0, res: '0, wd: b, tag: tag};
    nxt = p + 32'd4;
    case (i[6:0])
      T_LW:  begin x.rw = 1; x.chk_alu = 1; x.alu = a + im; x.chk_res = 1; x.res = rdat; end
      T_SW:  begin x.mw = 1; x.imm_src = 2'b01; x.chk_alu = 1; x.alu = a + im; end
      T_R:   begin x.rw = 1; x.chk_alu = 1; x.alu = funct_op(i, a, b, 1'b1);
                   x.chk_res = 1; x.res = x.alu; end
      T_I:   begin x.rw = 1; x.chk_alu = 1; x.alu = funct_op(i, a, im, 1'b0);
                   x.chk_res = 1; x.res = x.alu; end
      T_BEQ: begin x.imm_src = 2'b10; x.chk_alu = 1; x.alu = a - b;
                   if (a == b) nxt = p + im; end
      T_JAL: begin x.rw = 1; x.imm_src = 2'b11; x.chk_res = 1; x.res = p + 32'd4;
                   nxt = p + im; end
      default: ;
    endcase
  endtask

  // Monitor: compares on every falling edge, or on demand for the async reset check.
  always begin
    exp_t e;
    @(negedge clk or mon_req);
    if (q.size() > 0) begin
      e = q.pop_front();
      cmp($sformatf("%s pc", e.tag), pc, e.pc);
      if (!e.pc_only) begin
        cmp($sformatf("%s imm_src", e.tag), 32'(imm_src), 32'(e.imm_src));
        cmp($sformatf("%s reg_write", e.tag), 32'(reg_write), 32'(e.rw));
        cmp($sformatf("%s mem_write", e.tag), 32'(mem_write), 32'(e.mw));
        cmp($sformatf("%s write_data", e.tag), write_data, e.wd);
        if (e.chk_alu) cmp($sformatf("%s alu_result", e.tag), alu_result, e.alu);
        if (e.chk_res) cmp($sformatf("%s result", e.tag), result, e.res);
      end
    end
  end

  task automatic push_pc_only(input string tag);
    exp_t x;
    x = '{pc_only: 1'b1, pc: RESET_PC, imm_src: 2'b00, rw: 1'b0, mw: 1'b0, chk_alu: 1'b0,
          alu: '0, chk_res: 1'b0, res: '0, wd: '0, tag: tag};
    q.push_back(x);
  endtask

  task automatic drive_push(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] rdat, input string tag);
    exp_t        x;
    logic [31:0] nxt;
    instr = i; rd1 = a; rd2 = b; imm_ext = im; read_data = rdat;
    model(i, a, b, im, rdat, model_pc, tag, x, nxt);
    q.push_back(x);
    model_pc = nxt;
  endtask

  task automatic step(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic [31:0] rdat, input string tag);
    @(posedge clk);
    #1;
    drive_push(i, a, b, im, rdat, tag);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    logic [6:0]  op;
    logic [6:0]  ops [6];
    ops = '{T_LW, T_SW, T_R, T_I, T_BEQ, T_JAL};
    i = $urandom;
    if ($urandom_range(0, 6) == 6) begin
      op = 7'($urandom);
      while (op == T_LW || op == T_SW || op == T_R || op == T_I || op == T_BEQ || op == T_JAL)
        op = 7'($urandom);
    end else begin
      op = ops[$urandom_range(0, 5)];
    end
    i[6:0] = op;
    case ($urandom_range(0, 4))
      0: i[14:12] = 3'b000;
      1: i[14:12] = 3'b010;
      2: i[14:12] = 3'b110;
      3: i[14:12] = 3'b111;
      default: ;
    endcase
    return i;
  endfunction

  initial begin
    logic [31:0] a, b;
    model_pc = RESET_PC;
    repeat (2) begin
      @(posedge clk);
      #1;
      push_pc_only("reset_hold");
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_push(I_ADDI, 32'd0, 32'd0, 32'd5, 32'd0, "addi_first");
    step(I_SUB, 32'd3, 32'd5, $urandom, $urandom, "sub");
    step(I_ADDI30, 32'd3, 32'd0, 32'd5, $urandom, "addi_bit30");
    step(I_SLT, 32'hFFFF_FFFF, 32'd1, $urandom, $urandom, "slt_neg");
    step(I_SLT, 32'd1, 32'hFFFF_FFFF, $urandom, $urandom, "slt_swap");

    // Async reset mid-cycle, checked before any clock edge.
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    push_pc_only("async_reset");
    mon_req = ~mon_req;
    model_pc = RESET_PC;
    @(posedge clk);
    #1;
    push_pc_only("reset_held");
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_push(I_ADDI, 32'd0, 32'd0, 32'd5, 32'd0, "addi_after_reset");

    repeat (7) step(I_NOP, $urandom, $urandom, $urandom, $urandom, "nop");
    step(I_BEQ, 32'd7, 32'd7, 32'hFFFF_FFF8, $urandom, "beq_taken");
    repeat (2) step(I_NOP, $urandom, $urandom, $urandom, $urandom, "nop");
    step(I_BEQ, 32'd7, 32'd8, 32'hFFFF_FFF8, $urandom, "beq_not_taken");
    repeat (7) step(I_NOP, $urandom, $urandom, $urandom, $urandom, "nop");
    step(I_JAL, $urandom, $urandom, 32'h0000_0100, $urandom, "jal");
    step(I_LW, 32'h0000_1000, $urandom, 32'h0000_0010, 32'hCAFE_F00D, "lw");
    step(I_SW, 32'h0000_1000, 32'h1234_5678, 32'h0000_0020, $urandom, "sw");
    step(I_JAL, $urandom, $urandom, 32'hFFFF_FFFC - model_pc, $urandom, "jal_to_top");
    step(I_NOP, $urandom, $urandom, $urandom, $urandom, "pc_wrap");
    step(I_ADDI, 32'd0, 32'd0, 32'd5, 32'd0, "addi_after_wrap");

    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      step(rand_instr(), a, b, $urandom, $urandom, "rand");
    end

    @(posedge clk);
    for (int k = 0; k < 4 && q.size() != 0; k++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
